// File: rtl/pixel_frame_reader.sv
// Streams a WIDTH x HEIGHT frame from a 1-cycle-latency memory as valid/ready pixels with sof/sol/eol/eof; start->first pixel 3 cycles, 1 pix/clk.
// Backpressure absorbed by a 2-entry buffer gating the read strobe; PIXEL_READER_VFLIP_EN reads rows bottom-to-top.
module pixel_frame_reader #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_eof
);
    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
`ifdef PIXEL_READER_VFLIP_EN
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'((HEIGHT - 1) * WIDTH);
    localparam logic [ADDR_W-1:0] ROW_BACK   = ADDR_W'(2 * WIDTH - 1);
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              sof;
        logic              sol;
        logic              eol;
        logic              eof;
    } ent_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic              inflight_q;
    logic [3:0]        mark_q;
    ent_t              ent0_q;
    ent_t              ent1_q;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              done_q;

    logic              pop;
    logic              push;
    logic              rd_en;
    logic              last_col;
    logic              last_row;
    logic [2:0]        level;
    ent_t              new_ent;

    always_comb begin
        pop      = pix_valid & pix_ready;
        push     = inflight_q;
        level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en    = (state_q == RUN) && (level < 3'd2);
        last_col = (col_q == COL_W'(WIDTH - 1));
        last_row = (row_q == ROW_W'(HEIGHT - 1));
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        new_ent  = '{dat: mem_data, sof: mark_q[3], sol: mark_q[2], eol: mark_q[1], eof: mark_q[0]};
`ifdef PIXEL_READER_VFLIP_EN
        addr_d   = last_col ? (addr_q - ROW_BACK) : (addr_q + ADDR_W'(1));
`else
        addr_d   = addr_q + ADDR_W'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            mark_q     <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            occ_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            occ_q      <= occ_d;
            done_q     <= 1'b0;
            // ent0_q is always the head; entries shift forward on pop
            case ({push, pop})
                2'b10: if (occ_q == 2'd0) ent0_q <= new_ent; else ent1_q <= new_ent;
                2'b01: ent0_q <= ent1_q;
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= new_ent;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= new_ent;
                    end
                end
                default: ;
            endcase
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        addr_q  <= FIRST_ADDR;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        // row/col count output order, so markers hold regardless of flip
                        mark_q <= {(row_q == '0) && (col_q == '0), col_q == '0, last_col, last_row && last_col};
                        addr_q <= addr_d;
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                            if (last_row) state_q <= DRAIN;
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight_q && occ_d == 2'd0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_rd    = rd_en;
    assign mem_addr  = addr_q;
    assign pix_valid = (occ_q != 2'd0);
    assign pix_data  = pix_valid ? ent0_q.dat : '0;
    assign pix_sof   = pix_valid & ent0_q.sof;
    assign pix_sol   = pix_valid & ent0_q.sol;
    assign pix_eol   = pix_valid & ent0_q.eol;
    assign pix_eof   = pix_valid & ent0_q.eof;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && occ_q == 2'd2));
endmodule

// File: tb/tb_pixel_frame_reader.sv
// Bench for pixel_frame_reader at WIDTH=4, HEIGHT=2 with a memory returning addr+0x10.
module tb_pixel_frame_reader;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_rd;
    logic [15:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_sof, pix_sol, pix_eol, pix_eof;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_dat  [N];
    logic [15:0] exp_addr [N];
    logic [3:0]  exp_mark [N];

    pixel_frame_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    always #5 clk = ~clk;

    // synchronous memory: data one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0] + 8'h10;
        else        mem_data <= 8'($urandom);
    end

    task automatic build_model();
        for (int k = 0; k < N; k++) begin
            int r, c, mr;
            r = k / W;
            c = k % W;
`ifdef PIXEL_READER_VFLIP_EN
            mr = H - 1 - r;
`else
            mr = r;
`endif
            exp_addr[k] = 16'(mr * W + c);
            exp_dat[k]  = 8'(mr * W + c + 16'h10);
            exp_mark[k] = {k == 0, c == 0, c == W - 1, k == N - 1};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        #12;
        checks++;
        if ({busy, done, mem_rd, mem_addr, pix_data, pix_valid, pix_sof, pix_sol, pix_eol, pix_eof} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b addr=%h data=%h valid=%b, required all 0",
                     busy, done, mem_rd, mem_addr, pix_data, pix_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: ready=1, 1: alternating, 2: random, 3: ready=0 until cycle 10
    task automatic run_frame(input int mode, input int restart_cyc, input string name);
        int idx = 0, rd = 0, cyc = 1;
        bit fin = 1'b0;
        @(negedge clk);
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        while (!fin && cyc < 200) begin
            case (mode)
                0: pix_ready = 1'b1;
                1: pix_ready = cyc[0];
                2: pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = (cyc > 10);
            endcase
            start = (cyc == restart_cyc);
            #1;
            if (pix_valid) begin
                checks++;
                if (idx >= N) begin
                    errors++;
                    $display("FAIL %s_extra_pixel: pixel %0d data=%h, required only %0d pixels", name, idx, pix_data, N);
                end else if (pix_data !== exp_dat[idx] || {pix_sof, pix_sol, pix_eol, pix_eof} !== exp_mark[idx]) begin
                    errors++;
                    $display("FAIL %s_pixel%0d cyc%0d: data=%h marks=%b, required data=%h marks=%b",
                             name, idx, cyc, pix_data, {pix_sof, pix_sol, pix_eol, pix_eof}, exp_dat[idx], exp_mark[idx]);
                end
                if (pix_ready) idx++;
            end else begin
                checks++;
                if ({pix_sof, pix_sol, pix_eol, pix_eof, pix_data} !== '0) begin
                    errors++;
                    $display("FAIL %s_idle_marks cyc%0d: marks=%b data=%h, required 0", name, cyc,
                             {pix_sof, pix_sol, pix_eol, pix_eof}, pix_data);
                end
            end
            if (mem_rd) begin
                checks++;
                if (rd >= N) begin
                    errors++;
                    $display("FAIL %s_extra_read: read %0d addr=%h, required %0d reads", name, rd, mem_addr, N);
                end else if (mem_addr !== exp_addr[rd]) begin
                    errors++;
                    $display("FAIL %s_addr%0d: addr=%h, required %h", name, rd, mem_addr, exp_addr[rd]);
                end
                rd++;
                checks++;
                if (rd - idx > 2) begin
                    errors++;
                    $display("FAIL %s_outstanding cyc%0d: %0d, required <=2", name, cyc, rd - idx);
                end
            end
            if (mode == 0) begin
                checks++;
                if (pix_valid !== (cyc >= 3 && cyc <= 10)) begin
                    errors++;
                    $display("FAIL %s_valid_timing cyc%0d: valid=%b", name, cyc, pix_valid);
                end
            end
            if (mode == 3 && cyc == 10) begin
                checks++;
                if (rd != 2 || pix_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_stall_reads: reads=%0d valid=%b, required 2 and 1", name, rd, pix_valid);
                end
            end
            if (done) begin
                fin = 1'b1;
                checks++;
                if (idx != N || rd != N || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_done: xfers=%0d reads=%0d busy=%b, required %0d %0d 0", name, idx, rd, busy, N, N);
                end
                if (mode == 0) begin
                    checks++;
                    if (cyc != 11) begin
                        errors++;
                        $display("FAIL %s_done_cycle: cycle %0d, required 11", name, cyc);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy cyc%0d: busy=%b, required 1", name, cyc, busy);
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout: no done within 200 cycles (xfers=%0d)", name, idx);
        end
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b after done cycle, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset_midframe();
        int xf = 0;
        @(negedge clk);
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && xf < 3; n++) begin
            #1;
            if (pix_valid && pix_ready) xf++;
            @(negedge clk);
        end
        checks++;
        if (xf < 3) begin
            errors++;
            $display("FAIL midrst_reach: %0d transfers, required 3", xf);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_rd, mem_addr, pix_data, pix_valid, pix_sof, pix_sol, pix_eol, pix_eof} !== '0) begin
            errors++;
            $display("FAIL midrst_async: busy=%b rd=%b addr=%h data=%h valid=%b, required all 0",
                     busy, mem_rd, mem_addr, pix_data, pix_valid);
        end
        #1 rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pix_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale cyc%0d: valid=%b busy=%b rd=%b data=%h, required 0", n, pix_valid, busy, mem_rd, pix_data);
            end
        end
    endtask

    task automatic test_basic();        run_frame(0, -1, "basic");        endtask
    task automatic test_alternate();    run_frame(1, -1, "alternate");    endtask
    task automatic test_random();       for (int i = 0; i < 3; i++) run_frame(2, -1, "random"); endtask
    task automatic test_stall();        run_frame(3, -1, "stall");        endtask
    task automatic test_back_to_back(); run_frame(0, 5, "restart"); run_frame(0, -1, "after_done"); endtask
    task automatic test_reset_frame();  test_reset_midframe(); run_frame(0, -1, "post_reset"); endtask

    initial begin
        build_model();
        test_reset();
        test_basic();
        test_alternate();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
